metadata_merger: RTL
====================

# metadata_merger

Two-to-one AXI-Stream merger: the inverse end of the metadata split path. It arbitrates two independent metadata streams onto one output stream and tags each output beat with its source. Arbitration is round-robin with bounded burst ownership. A registered two-entry output stage sustains one beat per cycle with no combinational path from `axis_out_tready` to either input ready.

## Interface
Parameters:
- `DW`, 128, data width of all streams.
- `MAX_BURST`, 4, maximum consecutive beats granted to one source while the other is waiting (≥1).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `axis_in1_tdata`  in  DW  source 1 data.
- `axis_in1_tvalid`  in  1  source 1 valid.
- `axis_in1_tready`  out  1  source 1 ready.
- `axis_in2_tdata`  in  DW  source 2 data.
- `axis_in2_tvalid`  in  1  source 2 valid.
- `axis_in2_tready`  out  1  source 2 ready.
- `axis_out_tdata`  out  DW  merged data.
- `axis_out_tid`  out  1  source of the current beat: 0 = in1, 1 = in2.
- `axis_out_tvalid`  out  1  merged valid.
- `axis_out_tready`  in  1  downstream ready.

## Operation
- State:
  - `main` entry: valid, data, tid.
  - `skid` entry: valid, data, tid.
  - `owner`: 1 bit.
  - `cnt`: width $clog2(MAX_BURST+1).
- `accept = !skid_valid`. This is a registered term only.
- Select `sel`, combinational:
  - Both inputs valid: `sel = owner` if `cnt < MAX_BURST`, else `!owner`.
  - Exactly one input valid: `sel` = that input.
  - Neither input valid: `sel = owner`.
- Input readies:
  - `axis_inN_tready = resetn && accept && (sel == N)`.
  - The non-selected input is never ready.
- Input transfer:
  - Occurs on `tvalid && tready` of the selected input.
  - If `sel == owner`: `cnt <= cnt + 1`, saturating at `MAX_BURST`.
  - Otherwise: `owner <= sel`, `cnt <= 1`.
- Burst close: on a cycle with `accept == 1` and the owner's `tvalid == 0`, `cnt <= MAX_BURST`. This lets an idle owner lose priority immediately.
- Output stage is a standard skid pair. `axis_out_tvalid`, `axis_out_tdata` and `axis_out_tid` are driven from `main`.
- On output transfer, or when `main` is empty:
  - `main` loads `skid` if `skid_valid`, else the input beat if present.
  - `skid` then empties.
- Input transfer while `main` is valid and not draining: the beat goes to `skid`; `skid_valid <= 1`.
- Ordering: beats from each source leave in arrival order. No beat is dropped or duplicated.

## Timing
- Reset values (async assert, sync-safe deassert):
  - `main_valid = 0`, `skid_valid = 0`, all data/tid = 0.
  - `owner = 1`, `cnt = MAX_BURST`. The first contest after reset therefore goes to in1.
- During reset: both input readies are 0 combinationally via `resetn`, and `axis_out_tvalid = 0`.
- Reset mid-operation discards both buffered beats.
- Latency: input transfer at cycle t gives `axis_out_tvalid` at t+1 (empty stage).
- Throughput: 1 beat/cycle with `axis_out_tready` held high.
- Backpressure:
  - At most 2 beats buffered.
  - Input readies fall on the cycle after `skid` fills.
  - While `axis_out_tvalid && !axis_out_tready`, output data/tid stay stable.
- Simultaneous output drain and input transfer in the same cycle with `skid` empty: `main` reloads from the input, `skid` stays empty.
- `cnt` never wraps; it saturates at `MAX_BURST`.

## Structure
- Shared package `metadata_stream_pkg`:
  - Source-id constants `SRC_IN1 = 1'b0`, `SRC_IN2 = 1'b1`.
  - `DW` default constant, reused by the splitter/merger pair.
- One sub-module: `axis_skid_buffer`, width `DW+1` (data + tid). It holds the main/skid pair and exposes `in_ready = !skid_valid`.
- Arbitration (`sel`, `owner`, `cnt`) stays in `metadata_merger`.

## Test plan
- Only in1 streams A1, A2, A3 back-to-back, `out_tready = 1` → output A1, A2, A3 on consecutive cycles from t+1, tid = 0, `in1_tready` continuously 1, `in2_tready` 0.
- Both inputs always valid, `MAX_BURST = 4`, `out_tready = 1` → tid sequence 0,0,0,0,1,1,1,1,0,0,0,0; per-source data in order.
- Both valid, `out_tready` low for 3 cycles mid-stream → exactly 2 beats accepted, then both readies 0; output data/tid stable while stalled; after release, sequence continues with no loss or duplication.
- in1 sends 2 beats then drops valid while in2 is valid → grant moves to in2 on the next accept cycle. in1 revalidates during in2's burst → in2 keeps the grant until 4 beats or until it goes idle.
- Reset asserted with `main` and `skid` both full → `axis_out_tvalid` and both readies 0 immediately. After release with both inputs valid, the first accepted beat comes from in1 (tid = 0).
- `MAX_BURST = 1`, both valid → strict alternation of tid 0,1,0,1.

Source files
------------

// File: rtl/metadata_stream_pkg.sv
// Constants shared by the metadata splitter/merger pair.
package metadata_stream_pkg;

    localparam int DW = 128;

    localparam logic SRC_IN1 = 1'b0;
    localparam logic SRC_IN2 = 1'b1;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered output stage (main + skid) for an AXI-Stream path.
// The upstream ready depends only on registered state.
module axis_skid_buffer #(
    parameter int W = 129
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic         r_mainValid;
    logic [W-1:0] r_mainData;
    logic         r_skidValid;
    logic [W-1:0] r_skidData;

    logic         w_load;
    logic         w_inXfer;

    assign in_ready  = !r_skidValid;
    assign out_valid = r_mainValid;
    assign out_data  = r_mainData;

    assign w_load   = out_ready || !r_mainValid;
    assign w_inXfer = in_valid && !r_skidValid;

    // When main can take a beat the skid entry always wins, which keeps arrival order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mainValid <= 1'b0;
            r_mainData  <= '0;
            r_skidValid <= 1'b0;
            r_skidData  <= '0;
        end else if (w_load) begin
            if (r_skidValid) begin
                r_mainValid <= 1'b1;
                r_mainData  <= r_skidData;
                r_skidValid <= 1'b0;
            end else begin
                r_mainValid <= w_inXfer;
                if (w_inXfer) begin
                    r_mainData <= in_data;
                end
            end
        end else if (w_inXfer) begin
            r_skidValid <= 1'b1;
            r_skidData  <= in_data;
        end
    end

endmodule

// File: rtl/metadata_merger.sv
// Two-to-one AXI-Stream merger with round-robin, burst-bounded arbitration.
// Each output beat carries its source in axis_out_tid.
module metadata_merger #(
    parameter int DW        = metadata_stream_pkg::DW,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [DW-1:0] axis_in1_tdata,
    input  logic          axis_in1_tvalid,
    output logic          axis_in1_tready,
    input  logic [DW-1:0] axis_in2_tdata,
    input  logic          axis_in2_tvalid,
    output logic          axis_in2_tready,
    output logic [DW-1:0] axis_out_tdata,
    output logic          axis_out_tid,
    output logic          axis_out_tvalid,
    input  logic          axis_out_tready
);

    import metadata_stream_pkg::*;

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    logic          r_owner;
    logic [CW-1:0] r_cnt;

    logic          w_accept;
    logic          w_sel;
    logic          w_ownerValid;
    logic          w_xfer;
    logic [DW:0]   w_beat;
    logic [DW:0]   w_outBeat;

    assign w_ownerValid = (r_owner == SRC_IN2) ? axis_in2_tvalid : axis_in1_tvalid;

    // The owner keeps the grant until its burst budget is spent, then yields if the other side waits.
    always_comb begin
        w_sel = r_owner;
        if (axis_in1_tvalid && axis_in2_tvalid) begin
            w_sel = (r_cnt < CNT_MAX) ? r_owner : !r_owner;
        end else if (axis_in1_tvalid) begin
            w_sel = SRC_IN1;
        end else if (axis_in2_tvalid) begin
            w_sel = SRC_IN2;
        end
    end

    assign axis_in1_tready = resetn && w_accept && (w_sel == SRC_IN1);
    assign axis_in2_tready = resetn && w_accept && (w_sel == SRC_IN2);

    assign w_xfer = (w_sel == SRC_IN2) ? (axis_in2_tvalid && axis_in2_tready)
                                       : (axis_in1_tvalid && axis_in1_tready);
    assign w_beat = {w_sel, (w_sel == SRC_IN2) ? axis_in2_tdata : axis_in1_tdata};

    // An idle owner gets its count forced to the limit so a waiting source wins next time.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner <= SRC_IN2;
            r_cnt   <= CNT_MAX;
        end else if (w_xfer) begin
            if (w_sel == r_owner) begin
                r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
            end else begin
                r_owner <= w_sel;
                r_cnt   <= CW'(1);
            end
        end else if (w_accept && !w_ownerValid) begin
            r_cnt <= CNT_MAX;
        end
    end

    axis_skid_buffer #(
        .W(DW + 1)
    ) u_outStage (
        .clk       (clk),
        .resetn    (resetn),
        .in_data   (w_beat),
        .in_valid  (w_xfer),
        .in_ready  (w_accept),
        .out_data  (w_outBeat),
        .out_valid (axis_out_tvalid),
        .out_ready (axis_out_tready)
    );

    assign axis_out_tdata = w_outBeat[DW-1:0];
    assign axis_out_tid   = w_outBeat[DW];

endmodule
